litho_lot_sequencer: RTL and testbench
======================================

# litho_lot_sequencer

Parametrised lot-level successor to the single-wafer process controller. Sequences a whole lot of wafers through one reticle load and exposes a configurable number of fields per wafer, stepping between fields. Adds per-state timeouts, bounded alignment retry, abort and coded error reporting. Sits above the wafer/reticle loader, wafer/reticle stage and source submodules and drives their command inputs.

## Interface
- FIELDS, 4: exposure fields per wafer (≥1)
- LOT_W, 5: width of lot-size input / wafer counter
- TIMEOUT, 1024: max cycles allowed in any waiting state
- ALIGN_RETRIES, 2: extra alignment attempts after first failure
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_op  in  1  start lot; sampled in IDLE only
- lot_size  in  LOT_W  wafers in lot; latched with start_op; 0 means start is ignored
- safety_sensor  in  1  interlock, level
- abort  in  1  operator abort, level
- clear_err  in  1  leave ERROR
- env_ok, wl_ready, rl_ready, ws_done, rs_done  in  1  submodule status levels
- align_fail  in  1  qualifies ws_done in ALIGN
- cmd_wl_load, cmd_wl_unload, cmd_rl_load, cmd_rl_unload, cmd_ws_calib, cmd_ws_align, cmd_ws_step, cmd_ws_scan, cmd_rs_calib, cmd_rs_scan, cmd_source_active  out  1  commands
- process_state  out  4  current state code
- field_idx  out  clog2(FIELDS) (min 1)  field being exposed
- wafer_idx  out  LOT_W  wafer being processed
- err_code  out  3  0 none, 1 safety, 2 abort, 3 env, 4 timeout, 5 align
- busy  out  1  state ≠ IDLE and ≠ ERROR
- lot_done  out  1  one-cycle pulse on UNLOAD_RET→IDLE

## Operation
- States/codes: IDLE 0, ENV_CHECK 1, LOAD_RET 2, LOAD_WFR 3, SETUP 4, ALIGN 5, EXPOSE 6, STEP 7, UNLOAD_WFR 8, UNLOAD_RET 9, ERROR 15.
- Commands are Moore decode of state, held for the whole state: LOAD_RET rl_load; LOAD_WFR wl_load; SETUP ws_calib+rs_calib; ALIGN ws_align; EXPOSE ws_scan+rs_scan+source_active; STEP ws_step; UNLOAD_WFR wl_unload; UNLOAD_RET rl_unload; all others zero.
- Settle rule: status inputs are ignored on the first cycle of every state entry (incl. retry re-entry); exit conditions are evaluated from the second cycle.
- IDLE: start_op && lot_size≠0 → ENV_CHECK; latch lot_size, clear wafer_idx, field_idx, retry count, err_code.
- ENV_CHECK: env_ok → LOAD_RET. LOAD_RET: rl_ready → LOAD_WFR. LOAD_WFR: wl_ready → SETUP; field_idx←0, retry←0.
- SETUP: ws_done && rs_done → ALIGN.
- ALIGN: ws_done && !align_fail → EXPOSE. ws_done && align_fail: retry<ALIGN_RETRIES → re-enter ALIGN, retry+1; else ERROR code 5.
- EXPOSE: ws_done && rs_done → field_idx==FIELDS-1 ? UNLOAD_WFR : STEP. env_ok low in EXPOSE → ERROR code 3.
- STEP: ws_done → EXPOSE, field_idx+1.
- UNLOAD_WFR: wl_ready → wafer_idx==lot_size-1 ? UNLOAD_RET : LOAD_WFR (wafer_idx+1).
- UNLOAD_RET: rl_ready → IDLE, lot_done pulse.
- Global, while busy, priority order: safety_sensor → ERROR 1; abort → ERROR 2; env drop in EXPOSE → 3; timeout → 4; align exhaustion → 5. Safety/abort act on the first cycle too (not subject to settle rule).
- ERROR: all commands 0; err_code, field_idx, wafer_idx held. clear_err && !safety_sensor → IDLE (err_code kept until next start).

## Timing
- Reset: state IDLE, all commands 0, process_state 0, field_idx 0, wafer_idx 0, err_code 0, busy 0, lot_done 0, timer 0, retry 0.
- process_state equals the state register (no lag); busy, lot_done registered with state.
- Transition registered on clk edge after condition; minimum dwell 2 cycles per waiting state.
- Timer clears on every entry, increments each cycle in states 1–9; if timer==TIMEOUT-1 and no exit condition that cycle → ERROR 4. Exit on that same cycle wins over timeout.
- lot_size changes after start ignored. start_op while busy ignored.
- Reset mid-lot: immediate return to IDLE with reset values, no lot_done.

## Test plan
- Lot 2, FIELDS=4, all statuses answer 3 cycles after entry → state trace 1,2,3,4,5,6,7,6,7,6,7,6,8,3,…,8,9,0; 8 EXPOSE visits; lot_done one pulse; wafer_idx ends 1.
- align_fail with ws_done on first two ALIGN attempts, pass third → EXPOSE, no error; fail three times → ERROR, err_code 5.
- Hold rl_ready low in LOAD_RET, TIMEOUT=16 → ERROR code 4 exactly 16 cycles after entry; ready on cycle 16 instead → LOAD_WFR.
- safety_sensor during EXPOSE field 2 → next cycle ERROR, commands 0, err_code 1, field_idx 2; clear_err with sensor high stays; sensor low + clear_err → IDLE.
- safety_sensor and abort same cycle in SETUP → err_code 1; ws_done held high from SETUP into ALIGN → ALIGN not exited on its first cycle.
- start_op with lot_size 0 → stays IDLE; async reset mid-STEP → all outputs reset values same cycle.

Source files
------------

// File: rtl/litho_lot_sequencer.sv
// Lot-level lithography sequencer: one reticle load, LOT wafers, FIELDS exposures per wafer,
// with per-state timeout, bounded alignment retry, abort and coded error reporting.
module litho_lot_sequencer #(
  parameter int FIELDS        = 4,
  parameter int LOT_W         = 5,
  parameter int TIMEOUT       = 1024,
  parameter int ALIGN_RETRIES = 2,
  localparam int FW           = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_op,
  input  logic [LOT_W-1:0] lot_size,
  input  logic             safety_sensor,
  input  logic             abort,
  input  logic             clear_err,
  input  logic             env_ok,
  input  logic             wl_ready,
  input  logic             rl_ready,
  input  logic             ws_done,
  input  logic             rs_done,
  input  logic             align_fail,
  output logic             cmd_wl_load,
  output logic             cmd_wl_unload,
  output logic             cmd_rl_load,
  output logic             cmd_rl_unload,
  output logic             cmd_ws_calib,
  output logic             cmd_ws_align,
  output logic             cmd_ws_step,
  output logic             cmd_ws_scan,
  output logic             cmd_rs_calib,
  output logic             cmd_rs_scan,
  output logic             cmd_source_active,
  output logic [3:0]       process_state,
  output logic [FW-1:0]    field_idx,
  output logic [LOT_W-1:0] wafer_idx,
  output logic [2:0]       err_code,
  output logic             busy,
  output logic             lot_done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (ALIGN_RETRIES > 0) ? $clog2(ALIGN_RETRIES + 1) : 1;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ENV    = 4'd1;
  localparam logic [3:0] ST_LRET   = 4'd2;
  localparam logic [3:0] ST_LWFR   = 4'd3;
  localparam logic [3:0] ST_SETUP  = 4'd4;
  localparam logic [3:0] ST_ALIGN  = 4'd5;
  localparam logic [3:0] ST_EXPOSE = 4'd6;
  localparam logic [3:0] ST_STEP   = 4'd7;
  localparam logic [3:0] ST_UWFR   = 4'd8;
  localparam logic [3:0] ST_URET   = 4'd9;
  localparam logic [3:0] ST_ERROR  = 4'd15;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SAFETY  = 3'd1;
  localparam logic [2:0] ERR_ABORT   = 3'd2;
  localparam logic [2:0] ERR_ENV     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ALIGN   = 3'd5;

  // Command bit order: wl_load, wl_unload, rl_load, rl_unload, ws_calib, ws_align,
  // ws_step, ws_scan, rs_calib, rs_scan, source_active.
  function automatic logic [10:0] cmd_decode(input logic [3:0] st);
    case (st)
      ST_LRET:   cmd_decode = 11'h100;
      ST_LWFR:   cmd_decode = 11'h400;
      ST_SETUP:  cmd_decode = 11'h044;
      ST_ALIGN:  cmd_decode = 11'h020;
      ST_EXPOSE: cmd_decode = 11'h00B;
      ST_STEP:   cmd_decode = 11'h010;
      ST_UWFR:   cmd_decode = 11'h200;
      ST_URET:   cmd_decode = 11'h080;
      default:   cmd_decode = 11'h000;
    endcase
  endfunction

  logic [3:0]       state_r, state_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic [RW-1:0]    retry_r, retry_s;
  logic [FW-1:0]    field_r, field_s;
  logic [LOT_W-1:0] wafer_r, wafer_s;
  logic [LOT_W-1:0] lot_r, lot_s;
  logic [2:0]       err_r, err_s;
  logic [10:0]      cmd_r;
  logic             busy_r, lot_done_r;
  logic             settle_s, exit_s, timeout_s, reenter_s;

  // Exit condition of each waiting state, before the settle qualifier.
  always_comb begin
    exit_s = 1'b0;
    case (state_r)
      ST_ENV:    exit_s = env_ok;
      ST_LRET:   exit_s = rl_ready;
      ST_LWFR:   exit_s = wl_ready;
      ST_SETUP:  exit_s = ws_done && rs_done;
      ST_ALIGN:  exit_s = ws_done;
      ST_EXPOSE: exit_s = ws_done && rs_done;
      ST_STEP:   exit_s = ws_done;
      ST_UWFR:   exit_s = wl_ready;
      ST_URET:   exit_s = rl_ready;
      default:   exit_s = 1'b0;
    endcase
  end

  assign settle_s  = (timer_r == TW'(0));
  assign timeout_s = (timer_r == TW'(TIMEOUT - 1));

  // Next-state, counter and error-code logic; abort sources are checked in priority order.
  always_comb begin
    state_s   = state_r;
    retry_s   = retry_r;
    field_s   = field_r;
    wafer_s   = wafer_r;
    lot_s     = lot_r;
    err_s     = err_r;
    reenter_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_op && (lot_size != LOT_W'(0))) begin
          state_s = ST_ENV;
          lot_s   = lot_size;
          wafer_s = LOT_W'(0);
          field_s = FW'(0);
          retry_s = RW'(0);
          err_s   = ERR_NONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (clear_err && !safety_sensor) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERROR;
        end
      end
      ST_ENV, ST_LRET, ST_LWFR, ST_SETUP, ST_ALIGN, ST_EXPOSE, ST_STEP, ST_UWFR, ST_URET: begin
        if (safety_sensor) begin
          state_s = ST_ERROR;
          err_s   = ERR_SAFETY;
        end else if (abort) begin
          state_s = ST_ERROR;
          err_s   = ERR_ABORT;
        end else if (!settle_s && (state_r == ST_EXPOSE) && !env_ok) begin
          state_s = ST_ERROR;
          err_s   = ERR_ENV;
        end else if (!settle_s && exit_s) begin
          case (state_r)
            ST_ENV:  state_s = ST_LRET;
            ST_LRET: state_s = ST_LWFR;
            ST_LWFR: begin
              state_s = ST_SETUP;
              field_s = FW'(0);
              retry_s = RW'(0);
            end
            ST_SETUP: state_s = ST_ALIGN;
            ST_ALIGN: begin
              if (!align_fail) begin
                state_s = ST_EXPOSE;
              end else if (retry_r < RW'(ALIGN_RETRIES)) begin
                reenter_s = 1'b1;
                retry_s   = retry_r + RW'(1);
              end else begin
                state_s = ST_ERROR;
                err_s   = ERR_ALIGN;
              end
            end
            ST_EXPOSE: begin
              if (field_r == FW'(FIELDS - 1)) begin
                state_s = ST_UWFR;
              end else begin
                state_s = ST_STEP;
              end
            end
            ST_STEP: begin
              state_s = ST_EXPOSE;
              field_s = field_r + FW'(1);
            end
            ST_UWFR: begin
              if (wafer_r == (lot_r - LOT_W'(1))) begin
                state_s = ST_URET;
              end else begin
                state_s = ST_LWFR;
                wafer_s = wafer_r + LOT_W'(1);
              end
            end
            ST_URET: state_s = ST_IDLE;
            default: state_s = ST_ERROR;
          endcase
        end else if (timeout_s) begin
          state_s = ST_ERROR;
          err_s   = ERR_TIMEOUT;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Dwell timer restarts on every entry, including an alignment retry.
  always_comb begin
    timer_s = TW'(0);
    if ((state_s != state_r) || reenter_s) begin
      timer_s = TW'(0);
    end else if ((state_r != ST_IDLE) && (state_r != ST_ERROR)) begin
      timer_s = timer_r + TW'(1);
    end else begin
      timer_s = TW'(0);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      timer_r    <= TW'(0);
      retry_r    <= RW'(0);
      field_r    <= FW'(0);
      wafer_r    <= LOT_W'(0);
      lot_r      <= LOT_W'(0);
      err_r      <= ERR_NONE;
      cmd_r      <= 11'h000;
      busy_r     <= 1'b0;
      lot_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      retry_r    <= retry_s;
      field_r    <= field_s;
      wafer_r    <= wafer_s;
      lot_r      <= lot_s;
      err_r      <= err_s;
      cmd_r      <= cmd_decode(state_s);
      busy_r     <= (state_s != ST_IDLE) && (state_s != ST_ERROR);
      lot_done_r <= (state_r == ST_URET) && (state_s == ST_IDLE);
    end
  end

  assign {cmd_wl_load, cmd_wl_unload, cmd_rl_load, cmd_rl_unload, cmd_ws_calib, cmd_ws_align,
          cmd_ws_step, cmd_ws_scan, cmd_rs_calib, cmd_rs_scan, cmd_source_active} = cmd_r;
  assign process_state = state_r;
  assign field_idx     = field_r;
  assign wafer_idx     = wafer_r;
  assign err_code      = err_r;
  assign busy          = busy_r;
  assign lot_done      = lot_done_r;

endmodule

// File: tb/tb_litho_lot_sequencer.sv
// Self-checking bench for litho_lot_sequencer: vector table, directed corner sequences,
// and randomized lots compared against a trace-level model of the lot recipe.
module tb_litho_lot_sequencer;
  localparam int FIELDS = 4, LOT_W = 5, TIMEOUT = 16, ALIGN_RETRIES = 2;

  logic clk = 1'b0, reset;
  logic start_op, safety_sensor, abort, clear_err;
  logic [LOT_W-1:0] lot_size;
  logic env_ok, wl_ready, rl_ready, ws_done, rs_done, align_fail;
  logic cmd_wl_load, cmd_wl_unload, cmd_rl_load, cmd_rl_unload, cmd_ws_calib, cmd_ws_align;
  logic cmd_ws_step, cmd_ws_scan, cmd_rs_calib, cmd_rs_scan, cmd_source_active;
  logic [3:0] process_state;
  logic [1:0] field_idx;
  logic [LOT_W-1:0] wafer_idx;
  logic [2:0] err_code;
  logic busy, lot_done;

  litho_lot_sequencer #(.FIELDS(FIELDS), .LOT_W(LOT_W), .TIMEOUT(TIMEOUT),
                        .ALIGN_RETRIES(ALIGN_RETRIES)) dut (
    .clk(clk), .reset(reset), .start_op(start_op), .lot_size(lot_size),
    .safety_sensor(safety_sensor), .abort(abort), .clear_err(clear_err), .env_ok(env_ok),
    .wl_ready(wl_ready), .rl_ready(rl_ready), .ws_done(ws_done), .rs_done(rs_done),
    .align_fail(align_fail), .cmd_wl_load(cmd_wl_load), .cmd_wl_unload(cmd_wl_unload),
    .cmd_rl_load(cmd_rl_load), .cmd_rl_unload(cmd_rl_unload), .cmd_ws_calib(cmd_ws_calib),
    .cmd_ws_align(cmd_ws_align), .cmd_ws_step(cmd_ws_step), .cmd_ws_scan(cmd_ws_scan),
    .cmd_rs_calib(cmd_rs_calib), .cmd_rs_scan(cmd_rs_scan),
    .cmd_source_active(cmd_source_active), .process_state(process_state),
    .field_idx(field_idx), .wafer_idx(wafer_idx), .err_code(err_code), .busy(busy),
    .lot_done(lot_done));

  always #5 clk = ~clk;

  wire [10:0] cmd_all = {cmd_wl_load, cmd_wl_unload, cmd_rl_load, cmd_rl_unload, cmd_ws_calib,
                         cmd_ws_align, cmd_ws_step, cmd_ws_scan, cmd_rs_calib, cmd_rs_scan,
                         cmd_source_active};

  int n_pass = 0, n_total = 0;
  int kf [32];

  // One vector: inputs {start, env, rl, wl, ws, rs, af, safety, abort, clr}, lot, expected state/err.
  typedef struct {
    logic [9:0] ins;
    logic [4:0] lot;
    int         exp_state;
    int         exp_err;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [10:0] cmd_of(input int st);
    case (st)
      2: return 11'h100;
      3: return 11'h400;
      4: return 11'h044;
      5: return 11'h020;
      6: return 11'h00B;
      7: return 11'h010;
      8: return 11'h200;
      9: return 11'h080;
      default: return 11'h000;
    endcase
  endfunction

  task automatic clear_inputs();
    start_op = 1'b0; lot_size = 5'd0; safety_sensor = 1'b0; abort = 1'b0; clear_err = 1'b0;
    env_ok = 1'b0; wl_ready = 1'b0; rl_ready = 1'b0; ws_done = 1'b0; rs_done = 1'b0;
    align_fail = 1'b0;
  endtask

  // Submodule responder: status rises d cycles after entry; alignment reports as a one-cycle pulse.
  task automatic respond(input int s, input int c, input int d);
    rl_ready = 1'b0; wl_ready = 1'b0; ws_done = 1'b0; rs_done = 1'b0; align_fail = 1'b0;
    env_ok = 1'b1;
    case (s)
      2, 9: rl_ready = (c > d);
      3, 8: wl_ready = (c > d);
      4, 6: begin ws_done = (c > d); rs_done = (c > d); end
      5:    ws_done = (c == d + 1);
      7:    ws_done = (c > d);
      default: ;
    endcase
  endtask

  task automatic start_lot(input int n);
    @(negedge clk);
    clear_inputs();
    env_ok = 1'b1; start_op = 1'b1; lot_size = 5'(n);
    @(negedge clk);
    start_op = 1'b0;
  endtask

  // Step the responder until the given state/field is observed; returns at that negedge.
  task automatic goto(input int st, input int fld, input string name);
    int s, prev, c;
    bit ok;
    prev = -1; c = 0; ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      s = process_state;
      if (s != prev) c = 1; else c++;
      prev = s;
      if (s == st && field_idx == 2'(fld)) ok = 1'b1;
      else respond(s, c, 1);
    end
    rl_ready = 1'b0; wl_ready = 1'b0; ws_done = 1'b0; rs_done = 1'b0; align_fail = 1'b0;
    if (!ok) check({"reach_", name}, 0, 1);
  endtask

  // Run one lot with per-wafer forced alignment failures kf[], compare against the recipe trace.
  task automatic run_lot(input int n, input int dmin, input int dmax, input string name);
    int exp_q[$], obs_q[$];
    int exp_err, last_w, exp_expose, obs_expose, done_cnt, s, prev, c, d, wcnt, att, fcnt;
    bit reenter, fin;
    exp_err = 0; last_w = 0; exp_expose = 0; obs_expose = 0; done_cnt = 0;
    prev = 0; c = 0; d = 1; wcnt = -1; att = 0; fcnt = 0; reenter = 1'b0; fin = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2);
    for (int w = 0; w < n && exp_err == 0; w++) begin
      last_w = w;
      exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
      if (kf[w] > ALIGN_RETRIES) begin
        exp_q.push_back(15); exp_err = 5;
      end else begin
        exp_q.push_back(6);
        for (int f = 1; f < FIELDS; f++) begin exp_q.push_back(7); exp_q.push_back(6); end
        exp_q.push_back(8);
      end
    end
    if (exp_err == 0) begin exp_q.push_back(9); exp_q.push_back(0); end
    foreach (exp_q[i]) if (exp_q[i] == 6) exp_expose++;

    @(negedge clk);
    clear_inputs();
    env_ok = 1'b1; start_op = 1'b1; lot_size = 5'(n);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      start_op = 1'b0;
      lot_size = 5'($urandom);
      s = process_state;
      check({name, "_cmd"}, int'(cmd_all), int'(cmd_of(s)));
      check({name, "_busy"}, int'(busy), int'(s != 0 && s != 15));
      if (lot_done) done_cnt++;
      if (s != prev || reenter) begin
        if (s != prev) begin
          obs_q.push_back(s);
          if (s == 3) begin
            wcnt++; fcnt = 0;
            check({name, "_wafer_idx"}, int'(wafer_idx), wcnt);
          end
          if (s == 5) att = 0;
          if (s == 6) begin
            check({name, "_field_idx"}, int'(field_idx), fcnt);
            fcnt++; obs_expose++;
          end
        end
        c = 1; d = $urandom_range(dmin, dmax); reenter = 1'b0;
      end else begin
        c++;
      end
      prev = s;
      if (s == 0 || s == 15) begin
        fin = 1'b1;
      end else begin
        respond(s, c, d);
        if (s == 5 && ws_done) begin
          align_fail = (att < kf[(wcnt < 0) ? 0 : wcnt]);
          if (align_fail) begin att++; reenter = 1'b1; end
        end
      end
    end
    if (!fin) check({name, "_finished"}, 0, 1);
    check({name, "_trace_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_trace[%0d]", name, i), obs_q[i], exp_q[i]);
    check({name, "_err_code"}, int'(err_code), exp_err);
    check({name, "_lot_done_pulses"}, done_cnt, (exp_err == 0) ? 1 : 0);
    check({name, "_expose_visits"}, obs_expose, exp_expose);
    check({name, "_final_wafer"}, int'(wafer_idx), last_w);
    clear_inputs();
    if (s == 15) begin
      clear_err = 1'b1;
      @(posedge clk); #1;
      check({name, "_cleared"}, int'(process_state), 0);
      @(negedge clk);
      clear_err = 1'b0;
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", int'(process_state), 0);
    check("reset_cmd", int'(cmd_all), 0);
    check("reset_err", int'(err_code), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_idx", int'({field_idx, wafer_idx}), 0);
    check("reset_lot_done", int'(lot_done), 0);
    reset = 1'b0;

    tbl[0]  = '{10'h200, 5'd0, 0, 0};   // lot 0 start ignored
    tbl[1]  = '{10'h200, 5'd1, 1, 0};
    tbl[2]  = '{10'h100, 5'd0, 1, 0};   // settle cycle
    tbl[3]  = '{10'h100, 5'd0, 2, 0};
    tbl[4]  = '{10'h180, 5'd0, 2, 0};
    tbl[5]  = '{10'h180, 5'd0, 3, 0};
    tbl[6]  = '{10'h140, 5'd0, 3, 0};
    tbl[7]  = '{10'h140, 5'd0, 4, 0};
    tbl[8]  = '{10'h130, 5'd0, 4, 0};
    tbl[9]  = '{10'h136, 5'd0, 15, 1};  // safety beats abort and exit
    tbl[10] = '{10'h005, 5'd0, 15, 1};  // clear with sensor high
    tbl[11] = '{10'h001, 5'd0, 0, 1};
    tbl[12] = '{10'h002, 5'd0, 0, 1};   // abort ignored when idle
    tbl[13] = '{10'h200, 5'd3, 1, 0};
    tbl[14] = '{10'h002, 5'd0, 15, 2};  // abort on first cycle
    tbl[15] = '{10'h001, 5'd0, 0, 2};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      {start_op, env_ok, rl_ready, wl_ready, ws_done, rs_done, align_fail, safety_sensor, abort,
       clear_err} = tbl[i].ins;
      lot_size = tbl[i].lot;
      @(posedge clk); #1;
      check($sformatf("vec%0d_state", i), int'(process_state), tbl[i].exp_state);
      check($sformatf("vec%0d_err", i), int'(err_code), tbl[i].exp_err);
      check($sformatf("vec%0d_busy", i), int'(busy),
            int'(tbl[i].exp_state != 0 && tbl[i].exp_state != 15));
      check($sformatf("vec%0d_cmd", i), int'(cmd_all), int'(cmd_of(tbl[i].exp_state)));
      check($sformatf("vec%0d_lot_done", i), int'(lot_done), 0);
    end
    @(negedge clk);
    clear_inputs();

    // Timeout: rl_ready never comes, error 16 cycles after entering LOAD_RET.
    start_lot(1);
    goto(2, 0, "lret_a");
    repeat (15) @(negedge clk);
    check("timeout_c16_state", int'(process_state), 2);
    @(negedge clk);
    check("timeout_state", int'(process_state), 15);
    check("timeout_err", int'(err_code), 4);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("timeout_cleared", int'(process_state), 0);

    // Ready on the last allowed cycle wins over timeout.
    start_lot(1);
    goto(2, 0, "lret_b");
    repeat (15) @(negedge clk);
    rl_ready = 1'b1;
    @(negedge clk);
    rl_ready = 1'b0;
    check("ready_at_16_state", int'(process_state), 3);
    check("ready_at_16_err", int'(err_code), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;

    // ws_done held from SETUP into ALIGN: ALIGN must not exit on its first cycle.
    start_lot(1);
    goto(4, 0, "setup");
    ws_done = 1'b1; rs_done = 1'b1;
    @(negedge clk);
    check("setup_settle", int'(process_state), 4);
    @(negedge clk);
    check("align_entered", int'(process_state), 5);
    @(negedge clk);
    check("align_settle", int'(process_state), 5);
    @(negedge clk);
    check("align_exit", int'(process_state), 6);
    ws_done = 1'b0; rs_done = 1'b0;

    // Safety during EXPOSE of field 2.
    goto(6, 2, "expose_f2");
    safety_sensor = 1'b1;
    @(posedge clk); #1;
    check("safety_state", int'(process_state), 15);
    check("safety_cmd", int'(cmd_all), 0);
    check("safety_err", int'(err_code), 1);
    check("safety_field", int'(field_idx), 2);
    check("safety_busy", int'(busy), 0);
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk); #1;
    check("clear_sensor_high", int'(process_state), 15);
    @(negedge clk);
    safety_sensor = 1'b0;
    @(posedge clk); #1;
    check("clear_sensor_low", int'(process_state), 0);
    check("clear_err_kept", int'(err_code), 1);
    @(negedge clk);
    clear_inputs();

    // Asynchronous reset in the middle of STEP.
    start_lot(2);
    goto(7, 1, "step_f1");
    check("pre_reset_state", int'(process_state), 7);
    #2 reset = 1'b1;
    #1;
    check("async_state", int'(process_state), 0);
    check("async_cmd", int'(cmd_all), 0);
    check("async_idx", int'({field_idx, wafer_idx}), 0);
    check("async_err", int'(err_code), 0);
    check("async_busy", int'(busy), 0);
    check("async_lot_done", int'(lot_done), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();

    foreach (kf[i]) kf[i] = 0;
    run_lot(2, 2, 2, "nominal_lot2");
    kf[0] = 2;
    run_lot(1, 1, 3, "align_retry_pass");
    kf[0] = 3;
    run_lot(1, 1, 3, "align_exhaust");
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 3);
      foreach (kf[i]) kf[i] = ($urandom_range(0, 3) == 3) ? $urandom_range(0, 3) : 0;
      run_lot(n, 1, 4, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
